// File: rtl/fp_addsub_seq_if.sv
// Handshake bundle for fp_addsub_seq: launch request, operands, and the
// registered result/status returned by the sequencer.
interface fp_addsub_seq_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = EXP_W + MAN_W + 1;

   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] result;
   logic         busy;
   logic         done;
   logic [2:0]   flags;

   modport master (
      output start, op, a, b,
      input  result, busy, done, flags
   );

   modport slave (
      input  start, op, a, b,
      output result, busy, done, flags
   );
endinterface

// File: rtl/fp_addsub_seq.sv
// Sequential floating-point adder/subtractor (IEEE-style packing, denormals
// flushed to signed zero). One mantissa bit of alignment or normalisation
// per cycle keeps the datapath to a single shifter and one adder.
//
// Optional feature macro: FP_ADDSUB_RNE_EN
//   defined   -> round to nearest, ties to even
//   undefined -> truncate toward zero (inexact still flagged)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; operands captured on accept
// SPECIAL | NaN/Inf/zero screening, apply op to b's sign, unpack
// ALIGN   | swap so a has the larger exponent, shift b right 1/cycle
// ADD     | magnitude add or subtract, resolve result sign
// NORM    | carry right-shift or left-shift until hidden bit set
// ROUND   | round/truncate, overflow and flush handling, pack
// DONE    | result/flags valid, done pulse, busy low
module fp_addsub_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input logic              clk,
   input logic              reset,
   fp_addsub_seq_if.slave   bus
);
   localparam int W  = EXP_W + MAN_W + 1;
   localparam int M  = MAN_W + 4;
   localparam int CW = $clog2(MAN_W + 4);

   localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]    CAP      = CW'(MAN_W + 3);
   localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic               op_q, op_d;
   logic [W-1:0]       a_q, a_d, b_q, b_d;
   logic               sa_q, sa_d, sb_q, sb_d, sr_q, sr_d;
   logic [EXP_W-1:0]   ea_q, ea_d, eb_q, eb_d, er_q, er_d;
   logic [M-1:0]       ma_q, ma_d, mb_q, mb_d;
   logic [M:0]         mr_q, mr_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               flush_q, flush_d;
   logic [W-1:0]       result_q, result_d;
   logic [2:0]         flags_q, flags_d;

   logic               a_sign, b_sign_eff;
   logic [EXP_W-1:0]   a_exp, b_exp;
   logic [MAN_W-1:0]   a_frac, b_frac;
   logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   logic               rup;
   logic [MAN_W+1:0]   rsum;
   logic [EXP_W-1:0]   rexp;
   logic [MAN_W-1:0]   rfrac;

   assign a_sign     = a_q[W-1];
   assign b_sign_eff = b_q[W-1] ^ op_q;
   assign a_exp      = a_q[W-2:MAN_W];
   assign b_exp      = b_q[W-2:MAN_W];
   assign a_frac     = a_q[MAN_W-1:0];
   assign b_frac     = b_q[MAN_W-1:0];
   assign a_nan      = (a_exp == EXP_ONES) && (a_frac != '0);
   assign b_nan      = (b_exp == EXP_ONES) && (b_frac != '0);
   assign a_inf      = (a_exp == EXP_ONES) && (a_frac == '0);
   assign b_inf      = (b_exp == EXP_ONES) && (b_frac == '0);
   assign a_zero     = (a_exp == '0);
   assign b_zero     = (b_exp == '0);

   assign bus.result = result_q;
   assign bus.flags  = flags_q;
   assign bus.done   = (state_q == S_DONE);
   assign bus.busy   = (state_q != S_IDLE) && (state_q != S_DONE);

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         sr_q     <= 1'b0;
         ea_q     <= '0;
         eb_q     <= '0;
         er_q     <= '0;
         ma_q     <= '0;
         mb_q     <= '0;
         mr_q     <= '0;
         cnt_q    <= '0;
         flush_q  <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         sr_q     <= sr_d;
         ea_q     <= ea_d;
         eb_q     <= eb_d;
         er_q     <= er_d;
         ma_q     <= ma_d;
         mb_q     <= mb_d;
         mr_q     <= mr_d;
         cnt_q    <= cnt_d;
         flush_q  <= flush_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   // Next-state and datapath updates for each step of the sequence.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      sr_d     = sr_q;
      ea_d     = ea_q;
      eb_d     = eb_q;
      er_d     = er_q;
      ma_d     = ma_q;
      mb_d     = mb_q;
      mr_d     = mr_q;
      cnt_d    = cnt_q;
      flush_d  = flush_q;
      result_d = result_q;
      flags_d  = flags_q;
      rup      = 1'b0;
      rsum     = '0;
      rexp     = '0;
      rfrac    = '0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               op_d    = bus.op;
               state_d = S_SPECIAL;
            end
         end

         S_SPECIAL: begin
            state_d = S_DONE;
            flags_d = 3'b000;
            if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign_eff))) begin
               result_d = QNAN;
               flags_d  = 3'b100;
            end else if (a_inf) begin
               result_d = a_q;
            end else if (b_inf) begin
               result_d = {b_sign_eff, b_q[W-2:0]};
            end else if (a_zero && b_zero) begin
               result_d = {a_sign & b_sign_eff, {(W-1){1'b0}}};
            end else if (a_zero) begin
               result_d = {b_sign_eff, b_q[W-2:0]};
            end else if (b_zero) begin
               result_d = a_q;
            end else begin
               state_d = S_ALIGN;
               sa_d    = a_sign;
               sb_d    = b_sign_eff;
               ea_d    = a_exp;
               eb_d    = b_exp;
               ma_d    = {1'b1, a_frac, 3'b000};
               mb_d    = {1'b1, b_frac, 3'b000};
               cnt_d   = '0;
            end
         end

         S_ALIGN: begin
            if (eb_q > ea_q) begin
               sa_d = sb_q;
               sb_d = sa_q;
               ea_d = eb_q;
               eb_d = ea_q;
               ma_d = mb_q;
               mb_d = ma_q;
            end else if (ea_q == eb_q) begin
               state_d = S_ADD;
            end else if (cnt_q == CAP) begin
               // Beyond the cap b can only influence the sticky bit.
               mb_d    = {{(M-1){1'b0}}, |mb_q};
               eb_d    = ea_q;
               state_d = S_ADD;
            end else begin
               mb_d  = {1'b0, mb_q[M-1:2], |mb_q[1:0]};
               eb_d  = eb_q + 1'b1;
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_ADD: begin
            er_d    = ea_q;
            flush_d = 1'b0;
            state_d = S_NORM;
            if (sa_q == sb_q) begin
               mr_d = {1'b0, ma_q} + {1'b0, mb_q};
               sr_d = sa_q;
            end else if (ma_q == mb_q) begin
               mr_d = '0;
               sr_d = 1'b0;
            end else if (ma_q > mb_q) begin
               mr_d = {1'b0, ma_q - mb_q};
               sr_d = sa_q;
            end else begin
               mr_d = {1'b0, mb_q - ma_q};
               sr_d = sb_q;
            end
         end

         S_NORM: begin
            if (mr_q[M]) begin
               mr_d    = {1'b0, mr_q[M:2], |mr_q[1:0]};
               er_d    = er_q + 1'b1;
               state_d = S_ROUND;
            end else if (mr_q[M-1] || (mr_q == '0)) begin
               state_d = S_ROUND;
            end else begin
               mr_d = {mr_q[M-1:0], 1'b0};
               er_d = er_q - 1'b1;
               if (er_q == EXP_ONE) begin
                  flush_d = 1'b1;
                  state_d = S_ROUND;
               end
            end
         end

         S_ROUND: begin
            state_d = S_DONE;
            if (flush_q) begin
               result_d = {sr_q, {(W-1){1'b0}}};
               flags_d  = 3'b001;
            end else if (mr_q == '0) begin
               result_d = {sr_q, {(W-1){1'b0}}};
               flags_d  = 3'b000;
            end else if (er_q == EXP_ONES) begin
               result_d = {sr_q, EXP_ONES, {MAN_W{1'b0}}};
               flags_d  = 3'b011;
            end else begin
`ifdef FP_ADDSUB_RNE_EN
               rup = mr_q[2] & (mr_q[1] | mr_q[0] | mr_q[3]);
`else
               rup = 1'b0;
`endif
               rsum  = {1'b0, mr_q[M-1:3]} + {{(MAN_W+1){1'b0}}, rup};
               rexp  = er_q;
               rfrac = rsum[MAN_W-1:0];
               if (rsum[MAN_W+1]) begin
                  rexp  = er_q + 1'b1;
                  rfrac = rsum[MAN_W:1];
               end
               if (rexp == EXP_ONES) begin
                  result_d = {sr_q, EXP_ONES, {MAN_W{1'b0}}};
                  flags_d  = 3'b011;
               end else begin
                  result_d = {sr_q, rexp, rfrac};
                  flags_d  = {2'b00, |mr_q[2:0]};
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_fp_addsub_seq.sv
module tb_fp_addsub_seq;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   fp_addsub_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

   fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat;
      int          start_cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic prev_done = 1'b0;

`ifdef FP_ADDSUB_RNE_EN
   localparam logic [31:0] EXP_RND = 32'h3F800001;
`else
   localparam logic [31:0] EXP_RND = 32'h3F800000;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents done.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=%h required=none", bus.result);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("result", bus.result, e.res);
               chk("flags", {29'd0, bus.flags}, {29'd0, e.flg});
               chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
               chk("done_pulse_prev", {31'd0, prev_done}, 32'd0);
               if (e.lat != 0)
                  chk("latency", 32'(cyc - e.start_cyc + 1), 32'(e.lat));
            end
         end
         prev_done = bus.done;
      end
   end

   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [31:0] res, input logic [2:0] flg, input int lat);
      exp_t e;
      @(negedge clk);
      bus.a     = a;
      bus.b     = b;
      bus.op    = op;
      bus.start = 1'b1;
      e.res       = res;
      e.flg       = flg;
      e.lat       = lat;
      e.start_cyc = cyc;
      exp_q.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout actual=pending:%0d required=pending:0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic run(input logic [31:0] a, input logic [31:0] b, input logic op,
                      input logic [31:0] res, input logic [2:0] flg, input int lat);
      launch(a, b, op, res, flg, lat);
      wait_done();
   endtask

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_result", bus.result, 32'h0);
      chk("rst_flags", {29'd0, bus.flags}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);

      //  a             b             op    result        flags   latency
      run(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 0);
      run(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 0);
      run(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100, 3);
      run(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, 0);
      run(32'h3F800000, 32'h33C00000, 1'b0, EXP_RND,      3'b001, 0);
      run(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 0);
      run(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, 3);
      run(32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000, 3);
      run(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000, 3);
      run(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 0);
      run(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100, 3);
      run(32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 3'b000, 3);
      run(32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 3'b000, 0);
      run(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001, 0);

      // Abort during ALIGN: the aborted operation is never queued, so any
      // done it produced would be reported as unexpected.
      @(negedge clk);
      bus.a     = 32'h3F800000;
      bus.b     = 32'h33800000;
      bus.op    = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_mid_op", {31'd0, bus.busy}, 32'd1);
      reset     = 1'b1;
      bus.start = 1'b1;
      bus.a     = 32'h40000000;
      @(negedge clk);
      reset     = 1'b0;
      bus.start = 1'b0;
      chk("abort_result", bus.result, 32'h0);
      chk("abort_flags", {29'd0, bus.flags}, 32'd0);
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      repeat (40) @(negedge clk);

      // Retry, with a start during busy that must be ignored.
      launch(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 0);
      repeat (2) @(negedge clk);
      bus.a     = 32'h7F800000;
      bus.b     = 32'hFF800000;
      bus.op    = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();
      repeat (10) @(negedge clk);
      chk("idle_after_retry", {31'd0, bus.busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fp_addsub_seq.md
FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width; W = EXP_W+MAN_W+1.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, launch request; sampled only in IDLE.
REQ-006 SHALL have port op, input, 1, 0 = a+b, 1 = a-b; captured with start.
REQ-007 SHALL have ports a, b, input, W, IEEE-style operands; captured with start.
REQ-008 SHALL have port result, output, W, packed result; held until the next accepted start.
REQ-009 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when result is valid.
REQ-011 SHALL have port flags, output, 3, {invalid, overflow, inexact}, valid with done and held with result.

Function
REQ-012 SHALL implement FSM IDLE -> SPECIAL -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
REQ-013 SHALL ignore start while busy; no recapture, no restart.
REQ-014 SHALL compute with op applied by inverting b's sign in SPECIAL.
REQ-015 SHALL treat inputs with exponent 0 as signed zero (denormal flush).
REQ-016 SHALL, in SPECIAL, jump to DONE for: any NaN input -> canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0), invalid=1; Inf + opposite-sign Inf -> qNaN, invalid=1; single Inf or same-sign Infs -> that Inf; one zero operand -> the other operand; both zero -> +0, except -0 when both effective signs are negative.
REQ-017 SHALL hold mantissas as {hidden 1, fraction, guard, round, sticky}, MAN_W+4 bits, sign-magnitude.
REQ-018 SHALL swap in ALIGN so the larger-exponent operand is the reference, then shift the smaller right 1 bit per cycle, OR-ing shifted-out bits into sticky; alignment shift is capped at MAN_W+3 cycles, after which the smaller mantissa is all sticky.
REQ-019 SHALL, in ADD, add magnitudes on equal effective sign, else subtract smaller from larger magnitude, taking the larger's sign; an exact zero difference gives +0.
REQ-020 SHALL, in NORM, on carry-out shift right 1 (sticky preserved) and increment the exponent; otherwise shift left 1 per cycle, decrementing the exponent, until the hidden bit is 1.
REQ-021 SHALL flush to signed zero if the exponent reaches 0 during NORM.
REQ-022 SHALL produce signed Inf with overflow=1 if the exponent reaches all ones after NORM or ROUND.
REQ-023 SHALL set inexact=1 when any of guard/round/sticky is nonzero before rounding, or on overflow/flush.
REQ-024 SHALL pulse done for exactly one cycle in DONE, update result/flags in that same cycle, and deassert busy there.
REQ-025 SHALL give worst-case latency from start to done of at most 2*MAN_W+12 cycles; special cases take 3 cycles.

Reset
REQ-026 SHALL, on reset, set state to IDLE and result=0, flags=0, busy=0, done=0.
REQ-027 SHALL abort any operation in progress when reset is asserted mid-operation, with no done pulse for it.
REQ-028 SHALL let reset take priority over a simultaneous start.

Configuration
REQ-029 SHALL, with FP_ADDSUB_RNE_EN defined, round to nearest, ties-to-even, in ROUND (mantissa carry renormalises by one with exponent+1).
REQ-030 SHALL, without FP_ADDSUB_RNE_EN, truncate toward zero in ROUND; inexact is still reported.

Verification
REQ-031 SHALL cover a=0x3F800000, b=0x40000000, op=0 -> result 0x40400000, flags 000, one done pulse.
REQ-032 SHALL cover a=0x3F800000, b=0x3F800000, op=1 -> result 0x00000000, flags 000.
REQ-033 SHALL cover a=0x7F800000, b=0xFF800000, op=0 -> result 0x7FC00000, invalid=1, done in 3 cycles.
REQ-034 SHALL cover a=b=0x7F7FFFFF, op=0 -> result 0x7F800000, overflow=1, inexact=1.
REQ-035 SHALL cover a=0x3F800000 with b=0x33C00000 -> 0x3F800001 with RNE_EN, 0x3F800000 without; with b=0x33800000 -> 0x3F800000 (tie to even); inexact=1 in both cases.
REQ-036 SHALL cover reset pulsed during ALIGN, then start with a retried operation, and start asserted while busy -> no done for the aborted operation, result=0 after reset, the retried operation correct, and the busy-time start ignored.
